// File: rtl/conv_ofmap_writer.sv
// Output stage of the conv core: sums PE-row psum triples, rounds/saturates to Q4.12,
// assembles rows in a ping-pong line buffer and streams the finished map to DRAM.
module conv_ofmap_writer #(
  parameter int INWIDTH = 16,
  parameter int IN_FRAC = 12,
  parameter int PSUM_W  = 32,
  parameter int DO_W    = 5,
  parameter int DO_H    = 5,
  parameter int ADDR_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                psum_valid,
  output logic                psum_ready,
  input  logic [PSUM_W-1:0]   psum0,
  input  logic [PSUM_W-1:0]   psum1,
  input  logic [PSUM_W-1:0]   psum2,
  output logic                wr_valid,
  input  logic                wr_ready,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [INWIDTH-1:0]  wr_data,
  output logic                busy,
  output logic                done
);

  localparam int CW = (DO_W > 1) ? $clog2(DO_W) : 1;
  localparam int RW = $clog2(DO_H + 1);
  localparam int SW = PSUM_W + 2;
  localparam logic signed [SW-1:0] HALF = SW'(1) <<< (IN_FRAC - 1);
  localparam logic signed [SW-1:0] MAXV = (SW'(1) <<< (INWIDTH - 1)) - SW'(1);
  localparam logic signed [SW-1:0] MINV = -(SW'(1) <<< (INWIDTH - 1));

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state, w_next;

  logic [CW-1:0]      r_in_col, r_out_col, r_p_col;
  logic [RW-1:0]      r_in_row, r_out_row;
  logic               r_in_buf, r_out_buf, r_p_buf, r_p_vld;
  logic [1:0]         r_full;
  logic [ADDR_W-1:0]  r_base;
  logic [INWIDTH-1:0] r_p_data;
  logic [1:0][DO_W-1:0][INWIDTH-1:0] r_line;

  logic               w_run, w_acc, w_wr_valid, w_wr_fire, w_out_last_col, w_out_free, w_last_px;
  logic               w_p_last;
  logic signed [SW-1:0] w_sum, w_rnd;
  logic [INWIDTH-1:0] w_sat;
  logic [ADDR_W-1:0]  w_addr;

  assign w_run          = (r_state == S_RUN);
  assign psum_ready     = w_run && !r_full[r_in_buf] && (r_in_row < RW'(DO_H));
  assign w_acc          = psum_valid && psum_ready;
  assign w_wr_valid     = w_run && r_full[r_out_buf];
  assign w_wr_fire      = w_wr_valid && wr_ready;
  assign w_out_last_col = (r_out_col == CW'(DO_W - 1));
  assign w_out_free     = w_wr_fire && w_out_last_col;
  assign w_last_px      = w_out_free && (r_out_row == RW'(DO_H - 1));
  assign w_p_last       = r_p_vld && (r_p_col == CW'(DO_W - 1));

  // Round half toward +inf, then clamp to the Q4.12 range.
  assign w_sum = {{2{psum0[PSUM_W-1]}}, psum0} + {{2{psum1[PSUM_W-1]}}, psum1}
               + {{2{psum2[PSUM_W-1]}}, psum2};
  assign w_rnd = (w_sum + HALF) >>> IN_FRAC;

  always_comb begin
    w_sat = w_rnd[INWIDTH-1:0];
    if (w_rnd > MAXV)      w_sat = MAXV[INWIDTH-1:0];
    else if (w_rnd < MINV) w_sat = MINV[INWIDTH-1:0];
  end

  assign w_addr   = r_base + ADDR_W'(r_out_row) * ADDR_W'(DO_W) + ADDR_W'(r_out_col);
  assign wr_valid = w_wr_valid;
  assign wr_addr  = w_wr_valid ? w_addr : '0;
  assign wr_data  = w_wr_valid ? r_line[r_out_buf][r_out_col] : '0;
  assign busy     = (r_state == S_RUN) || (r_state == S_DONE);
  assign done     = (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last_px) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Input pointers advance at acceptance so psum_ready already sees the next line's flag;
  // the pipeline register carries the destination slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_base    <= '0;
      r_in_col  <= '0;
      r_in_row  <= '0;
      r_in_buf  <= 1'b0;
      r_out_col <= '0;
      r_out_row <= '0;
      r_out_buf <= 1'b0;
      r_full    <= '0;
      r_p_vld   <= 1'b0;
      r_p_col   <= '0;
      r_p_buf   <= 1'b0;
      r_p_data  <= '0;
    end else if (r_state == S_IDLE) begin
      r_p_vld <= 1'b0;
      if (start) begin
        r_base    <= base_addr;
        r_in_col  <= '0;
        r_in_row  <= '0;
        r_in_buf  <= 1'b0;
        r_out_col <= '0;
        r_out_row <= '0;
        r_out_buf <= 1'b0;
        r_full    <= '0;
      end
    end else begin
      r_p_vld <= w_acc;
      if (w_acc) begin
        r_p_data <= w_sat;
        r_p_col  <= r_in_col;
        r_p_buf  <= r_in_buf;
        if (r_in_col == CW'(DO_W - 1)) begin
          r_in_col <= '0;
          r_in_row <= r_in_row + RW'(1);
          r_in_buf <= ~r_in_buf;
        end else begin
          r_in_col <= r_in_col + CW'(1);
        end
      end
      for (int b = 0; b < 2; b++) begin
        if (w_p_last && (r_p_buf == 1'(b)))          r_full[b] <= 1'b1;
        else if (w_out_free && (r_out_buf == 1'(b))) r_full[b] <= 1'b0;
      end
      if (w_wr_fire) begin
        if (w_out_last_col) begin
          r_out_col <= '0;
          r_out_row <= r_out_row + RW'(1);
          r_out_buf <= ~r_out_buf;
        end else begin
          r_out_col <= r_out_col + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_p_vld) r_line[r_p_buf][r_p_col] <= r_p_data;
  end

endmodule

// File: tb/tb_conv_ofmap_writer.sv
// Randomized bench for conv_ofmap_writer: frames of psum triples are scored against an
// arithmetic reference of the sum/round/saturate rule and the raster address map.
module tb_conv_ofmap_writer;
  localparam int N = 25;

  logic        clk = 1'b0;
  logic        rst, start, psum_valid, psum_ready, wr_valid, wr_ready, busy, done;
  logic [15:0] base_addr, wr_addr, wr_data;
  logic [31:0] psum0, psum1, psum2;

  conv_ofmap_writer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .psum_valid(psum_valid), .psum_ready(psum_ready),
    .psum0(psum0), .psum1(psum1), .psum2(psum2),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_err = 0;
  int          wr_idx, acc_cnt, done_cnt;
  logic [31:0] p0 [N], p1 [N], p2 [N];
  logic [15:0] exp_d [N];
  logic [15:0] exp_base, mon_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_q(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b)) + longint'($signed(c));
    s = (s + 2048) >>> 12;
    if (s > 32767)       s = 32767;
    else if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  // Write/accept/done monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (psum_valid && psum_ready) acc_cnt++;
    if (done) done_cnt++;
    if (wr_valid && wr_ready) begin
      if (wr_idx < N) begin
        mon_addr = exp_base + 16'(wr_idx);
        chk("wr_addr", wr_addr, mon_addr);
        chk("wr_data", wr_data, exp_d[wr_idx]);
      end else begin
        chk("wr_count", wr_idx + 1, N);
      end
      wr_idx++;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic feed(input int n, input int gap_pct, input bit mid_start);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      bit acc = 1'b0;
      while ($urandom_range(99) < gap_pct) begin psum_valid = 1'b0; step(); end
      psum_valid = 1'b1; psum0 = p0[k]; psum1 = p1[k]; psum2 = p2[k];
      if (mid_start && k == 12) begin start = 1'b1; base_addr = 16'h5555; end
      while (!acc && t < 3000) begin
        @(negedge clk); acc = psum_ready;
        step(); start = 1'b0; t++;
      end
      if (!acc) begin chk("feed_timeout", k, n); break; end
    end
    psum_valid = 1'b0;
  endtask

  task automatic ready_drv(input int pct, input int hold);
    int c = 0;
    wr_ready = 1'b0;
    if (hold > 0) begin
      repeat (hold) step();
      @(negedge clk);
      chk("bp_acc", acc_cnt, 10);
      chk("bp_ready", psum_ready, 0);
      chk("bp_wrv", wr_valid, 1);
      chk("bp_addr", wr_addr, exp_base);
      chk("bp_data", wr_data, exp_d[0]);
      repeat (3) step();
      @(negedge clk);
      chk("bp_hold", wr_data, exp_d[0]);
      chk("bp_acc2", acc_cnt, 10);
      step();
    end
    while (wr_idx < N && c < 5000) begin
      wr_ready = ($urandom_range(99) < pct);
      step(); c++;
    end
    wr_ready = 1'b1;
    if (wr_idx < N) chk("wr_timeout", wr_idx, N);
  endtask

  task automatic frame(input logic [15:0] base, input int gap, input int pct,
                       input int hold, input bit mid);
    int t = 0;
    for (int k = 0; k < N; k++) exp_d[k] = ref_q(p0[k], p1[k], p2[k]);
    exp_base = base; wr_idx = 0; acc_cnt = 0; done_cnt = 0;
    base_addr = base; start = 1'b1; step(); start = 1'b0;
    chk("busy_run", busy, 1);
    fork
      feed(N, gap, mid);
      ready_drv(pct, hold);
    join
    @(negedge clk);
    while (!done && t < 50) begin @(negedge clk); t++; end
    chk("done_hi", done, 1);
    @(negedge clk);
    chk("done_lo", done, 0);
    chk("busy_lo", busy, 0);
    chk("n_wr", wr_idx, N);
    chk("done_cnt", done_cnt, 1);
    chk("n_acc", acc_cnt, N);
    step();
  endtask

  task automatic fill_rand();
    for (int k = 0; k < N; k++) begin
      p0[k] = $signed($urandom) >>> $urandom_range(6, 12);
      p1[k] = $signed($urandom) >>> $urandom_range(6, 12);
      p2[k] = $signed($urandom) >>> $urandom_range(6, 12);
    end
  endtask

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; base_addr = '0; psum_valid = 1'b0; wr_ready = 1'b0;
    psum0 = '0; psum1 = '0; psum2 = '0;
    wr_idx = 0; acc_cnt = 0; done_cnt = 0; exp_base = '0;
    #12;
    chk("rst_ctl", {psum_ready, wr_valid, busy, done}, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    @(negedge clk); rst = 1'b0;
    step();

    // Basic: 1.0 + 1.0 + 1.0 everywhere.
    for (int k = 0; k < N; k++) begin p0[k] = 32'h0100_0000; p1[k] = 32'h0100_0000; p2[k] = 32'h0100_0000; end
    frame(16'h0100, 0, 100, 0, 1'b0);

    // Rounding and saturation corners, then random; base near the top to check wrap.
    fill_rand();
    p0[0] = 32'h0000_0800; p1[0] = '0; p2[0] = '0;
    p0[1] = 32'hFFFF_F800; p1[1] = '0; p2[1] = '0;
    p0[2] = 32'hFFFF_F7FF; p1[2] = '0; p2[2] = '0;
    p0[3] = 32'h7F00_0000; p1[3] = 32'h7F00_0000; p2[3] = 32'h7F00_0000;
    p0[4] = 32'h8100_0000; p1[4] = 32'h8100_0000; p2[4] = 32'h8100_0000;
    p0[5] = 32'hFF00_0000; p1[5] = 32'hFF00_0000; p2[5] = 32'hFF00_0000;
    frame(16'hFFF0, 30, 60, 0, 1'b0);

    // Backpressure from start.
    fill_rand();
    frame(16'h0300, 0, 100, 40, 1'b0);

    // Protocol: ramp data, random gaps/ready, stray start mid-frame.
    for (int k = 0; k < N; k++) begin p0[k] = 32'(k) << 24; p1[k] = '0; p2[k] = '0; end
    frame(16'h0400, 40, 50, 0, 1'b1);

    // Reset mid-frame after 7 accepts and 3 writes.
    fill_rand();
    for (int k = 0; k < N; k++) exp_d[k] = ref_q(p0[k], p1[k], p2[k]);
    exp_base = 16'h0200; wr_idx = 0; acc_cnt = 0; done_cnt = 0; wr_ready = 1'b0;
    base_addr = 16'h0200; start = 1'b1; step(); start = 1'b0;
    feed(7, 0, 1'b0);
    wr_ready = 1'b1; t = 0;
    while (wr_idx < 3 && t < 100) begin step(); t++; end
    wr_ready = 1'b0;
    chk("pre_acc", acc_cnt, 7);
    chk("pre_nwr", wr_idx, 3);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ctl", {psum_ready, wr_valid, busy, done}, 0);
    chk("mid_rst_addr", wr_addr, 0);
    chk("mid_rst_data", wr_data, 0);
    wr_ready = 1'b1; psum_valid = 1'b1;
    repeat (3) step();
    #2 rst = 1'b0;
    repeat (6) step();
    chk("post_nwr", wr_idx, 3);
    chk("post_done", done_cnt, 0);
    chk("post_acc", acc_cnt, 7);
    psum_valid = 1'b0;

    // Fresh frame after the abort.
    fill_rand();
    frame(16'h0500, 20, 70, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/conv_ofmap_writer.md
Name: conv_ofmap_writer

Overview:
- Output stage downstream of the 3x5 PE array in the conv core.
- Each cycle it can accept one triple of partial sums, one per PE row, for a single output pixel. It sums the triple, rounds and saturates the result to Q4.12, and assembles output rows in a ping-pong line buffer.
- It writes the finished DO_W x DO_H output map back to DRAM as a serial word stream and pulses done at the end of the frame.

Parameters:
- INWIDTH, 16, output word width (Q4.12 data)
- IN_FRAC, 12, fractional bits of the output word
- PSUM_W, 32, width of each incoming psum (Q8.24, the product of two Q4.12 values accumulated)
- DO_W, 5, output map width
- DO_H, 5, output map height
- ADDR_W, 16, DRAM word address width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse that begins a frame
- base_addr  in  ADDR_W  DRAM word address of output pixel (0,0); latched on start
- psum_valid  in  1  psum triple valid
- psum_ready  out  1  block can accept a triple this cycle
- psum0, psum1, psum2  in  PSUM_W each  signed psums from PE rows 1..3
- wr_valid  out  1  DRAM write request
- wr_ready  in  1  DRAM accepts the write
- wr_addr  out  ADDR_W  write address
- wr_data  out  INWIDTH  signed Q4.12 result
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last write is accepted

Behaviour:
- Reset: asynchronous, active-high. State goes to IDLE. psum_ready=0, wr_valid=0, wr_addr=0, wr_data=0, busy=0, done=0. All counters and both line-full flags are cleared.
- FSM: IDLE -> RUN on start; RUN -> DONE when the write of element (DO_H-1, DO_W-1) is accepted; DONE -> IDLE after exactly 1 cycle.
  - done=1 only in DONE.
  - busy=1 in RUN and DONE.
  - start outside IDLE is ignored.
- psum_valid in IDLE or DONE is ignored, and psum_ready=0 in those states.
- Input order is raster: col 0..DO_W-1 within a row, rows 0..DO_H-1. A triple is accepted when psum_valid and psum_ready are both 1.
- Input side:
  - Counters in_col and in_row, plus in_buf (0/1) selecting the line being filled.
  - psum_ready=1 in RUN when line[in_buf] is not full and in_row<DO_H.
- Arithmetic pipeline, one register stage:
  - s = psum0+psum1+psum2, sign-extended to PSUM_W+2 bits.
  - r = (s + 2^(IN_FRAC-1)) >>> IN_FRAC. This is round half toward +inf.
  - Saturate r to [-2^(INWIDTH-1), 2^(INWIDTH-1)-1].
  - A triple accepted in cycle t is stored in line[in_buf][in_col] at the edge ending cycle t+1.
  - When the stored element is col DO_W-1, line[in_buf] is marked full in that same cycle and in_buf toggles.
- Output side:
  - Counters out_col and out_row, plus out_buf.
  - wr_valid is asserted starting the cycle after line[out_buf] becomes full.
  - wr_addr = base_addr + out_row*DO_W + out_col, modulo 2^ADDR_W.
  - wr_data = line[out_buf][out_col].
  - wr_addr and wr_data are held stable while wr_valid=1 and wr_ready=0.
  - On handshake, out_col increments. After col DO_W-1 is accepted, line[out_buf] is cleared, out_buf toggles and out_row increments.
  - wr_valid stays high back-to-back across a line boundary if the other line is already full.
- Simultaneous events: if the input side marks one line full while the output side frees the other line in the same cycle, both updates take effect. The full flags are per-line, so there is no conflict.
- Backpressure limit: with wr_ready held 0, at most 2*DO_W triples are accepted before psum_ready drops.
- Counters: in_row stops at DO_H. After the final triple, psum_ready stays 0 until IDLE.
- Reset mid-frame aborts immediately. Buffered data is discarded, and no further writes or done are produced.

Test Plan:
- Basic path: start with base_addr=0x0100, wr_ready=1; send 25 triples of psum0=psum1=psum2=0x01000000 (1.0 each). Required: 25 writes of 0x3000 to addresses 0x0100..0x0118 in order, then done high for exactly 1 cycle, then busy=0.
- Rounding:
  - psum0=0x00000800, psum1=psum2=0 -> 0x0001.
  - psum0=0xFFFFF800 (-0.5), others 0 -> 0x0000.
  - psum0=0xFFFFF7FF, others 0 -> 0xFFFF.
- Saturation:
  - All three psums 0x7F000000 -> 0x7FFF.
  - All three 0x81000000 -> 0x8000.
  - All three 0xFF000000 (-1.0) -> 0xD000.
- Backpressure: wr_ready=0 from start with psum_valid=1 continuously. Required: exactly 10 triples accepted, then psum_ready=0. wr_valid=1 with wr_addr=base_addr and constant wr_data until wr_ready rises. After that, the frame completes with all 25 values correct and in order.
- Protocol: random psum_valid gaps plus random wr_ready toggling, with per-pixel values psum0=(row*5+col)<<24 and others 0. Required: wr_data sequence 0x0000, 0x1000, ... 0x7FFF (saturated from pixel 8 onward). A second start pulsed mid-frame is ignored.
- Reset mid-operation: assert rst after 7 accepted triples and 3 writes. Required: all outputs return to their reset values in the same cycle without waiting for a clock edge, with no further writes and no done pulse. A subsequent fresh frame runs correctly.
